instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 16: instruction width; opcode in bits [INSTR_W-1:INSTR_W-3].
REQ-002 SHALL have parameter ADDR_W, default 13: address width; operand in bits [ADDR_W-1:0]; INSTR_W >= ADDR_W+3 is required.
REQ-003 SHALL have parameter ROWS, default 4: words moved per LOAD_WEIGHT/LOAD_INPUT burst, 1..2**ADDR_W.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  instr  in  INSTR_W  instruction word
  instr_valid  in  1  instr presented
  instr_ready  out  1  sequencer can accept
  compute_done  in  1  array finished RUN
  base_address  out  ADDR_W  latched base
  mem_addr  out  ADDR_W  current burst address
  load_weight  out  1  weight-memory read strobe
  load_input  out  1  activation-memory read strobe
  start  out  1  one-cycle compute kick
  busy  out  1  not IDLE
  halted  out  1  sticky HALT seen
  illegal  out  1  sticky illegal opcode seen

Function
REQ-005 SHALL accept an instruction only on a cycle with instr_valid=1 and instr_ready=1; instr_ready SHALL be 1 exactly in IDLE.
REQ-006 SHALL implement states IDLE, BURST_W, BURST_I, KICK, WAIT, HALT.
REQ-007 Opcode 000 NOP SHALL stay IDLE with no output change.
REQ-008 Opcode 001 LOAD_ADDR SHALL set base_address to operand on the accept edge, visible the next cycle; remain IDLE.
REQ-009 Opcode 010 LOAD_WEIGHT SHALL go to BURST_W; for exactly ROWS consecutive cycles starting the cycle after accept, load_weight=1 and mem_addr=base_address+i (i=0..ROWS-1), modulo 2**ADDR_W; then IDLE.
REQ-010 Opcode 011 LOAD_INPUT SHALL behave as REQ-009 using BURST_I and load_input.
REQ-011 Opcode 100 RUN SHALL go to KICK (start=1 for one cycle), then WAIT until compute_done=1 is sampled, then IDLE; compute_done SHALL be ignored outside WAIT.
REQ-012 Opcode 111 HALT SHALL go to HALT; halted=1 and instr_ready=0 until reset.
REQ-013 Opcodes 101/110 SHALL set illegal=1 (sticky) and be treated as NOP.
REQ-014 load_weight and load_input SHALL never both be 1; mem_addr SHALL be 0 outside bursts.
REQ-015 busy SHALL equal (state != IDLE) and (state != HALT).
REQ-016 instr_valid while instr_ready=0 SHALL be ignored; the producer holds instr.

Reset
REQ-017 reset=1 at any edge, including mid-burst or in WAIT/HALT, SHALL force IDLE and zero every output the next cycle, except instr_ready=1.
REQ-018 Burst index and all sticky flags SHALL clear on reset.

Configuration
REQ-019 With macro INSTR_SEQUENCER_PERF_EN defined, SHALL add output busy_cycles (32 bits): counts cycles with busy=1, saturates at 2**32-1, cleared by reset.
REQ-020 Without INSTR_SEQUENCER_PERF_EN, busy_cycles SHALL not exist and no counter logic is synthesised.

Structure
REQ-021 Opcode constants and the state enum SHALL live in shared package tpu_pkg.
REQ-022 Burst address generation SHALL be sub-module burst_addr_gen (base, ROWS, start -> addr, active, last).

Verification
REQ-023 LOAD_ADDR 0x0010, then LOAD_WEIGHT -> load_weight high 4 cycles, mem_addr 0x0010,0x0011,0x0012,0x0013; instr_ready low during burst.
REQ-024 LOAD_ADDR 0x1FFE, LOAD_INPUT -> mem_addr 0x1FFE,0x1FFF,0x0000,0x0001 with load_input=1.
REQ-025 RUN with compute_done pulsed 5 cycles after start -> start one cycle, busy high through WAIT, instr_ready 1 the cycle after done.
REQ-026 Opcode 101 -> illegal=1, state IDLE; subsequent LOAD_ADDR 0x0003 -> base_address=0x0003, illegal still 1.
REQ-027 reset asserted on 3rd burst cycle -> next cycle load_weight=0, mem_addr=0, busy=0, instr_ready=1.
REQ-028 HALT, then instr_valid=1 with LOAD_ADDR -> halted=1, base_address unchanged, until reset.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared opcode and sequencer-state definitions for the TPU control path.
package tpu_pkg;

   typedef enum logic [2:0] {
      OP_NOP         = 3'b000,
      OP_LOAD_ADDR   = 3'b001,
      OP_LOAD_WEIGHT = 3'b010,
      OP_LOAD_INPUT  = 3'b011,
      OP_RUN         = 3'b100,
      OP_RSVD5       = 3'b101,
      OP_RSVD6       = 3'b110,
      OP_HALT        = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BURST_W,
      S_BURST_I,
      S_KICK,
      S_WAIT,
      S_HALT
   } state_t;

   // Reserved opcodes flag an error and otherwise act as NOP.
   function automatic logic is_illegal(input opcode_t op);
      return (op == OP_RSVD5) || (op == OP_RSVD6);
   endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: after a start pulse, emits ROWS consecutive
// addresses base+i (wrapping modulo 2**ADDR_W), one per cycle.
module burst_addr_gen
   import tpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned ROWS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr,
   output logic              active,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS - 1);

   logic              r_active;
   logic [ADDR_W-1:0] r_idx;

   // Burst index: starts at 0 the cycle after start, stops after LAST_IDX.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_active <= 1'b0;
         r_idx    <= '0;
      end else if (start) begin
         r_active <= 1'b1;
         r_idx    <= '0;
      end else if (r_active) begin
         if (r_idx == LAST_IDX) begin
            r_active <= 1'b0;
            r_idx    <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign active = r_active;
   assign last   = r_active && (r_idx == LAST_IDX);
   assign addr   = r_active ? (base + r_idx) : '0;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: decodes a 3-bit opcode, drives weight/input memory
// bursts, kicks the compute array and waits for it to finish.
// Optional feature: define INSTR_SEQUENCER_PERF_EN to add the busy_cycles counter.
module instr_sequencer
   import tpu_pkg::*;
#(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned ROWS    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               compute_done,
   output logic [ADDR_W-1:0]  base_address,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               load_weight,
   output logic               load_input,
   output logic               start,
   output logic               busy,
   output logic               halted,
   output logic               illegal
`ifdef INSTR_SEQUENCER_PERF_EN
   ,
   output logic [31:0]        busy_cycles
`endif
);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_base;
   logic              r_illegal;
   opcode_t           w_op;
   logic [ADDR_W-1:0] w_operand;
   logic              w_accept;
   logic              w_burst_start;
   logic [ADDR_W-1:0] w_burst_addr;
   logic              w_burst_active;
   logic              w_burst_last;

   assign w_op          = opcode_t'(instr[INSTR_W-1 -: 3]);
   assign w_operand     = instr[ADDR_W-1:0];
   assign w_accept      = instr_valid && (r_state == S_IDLE);
   assign w_burst_start = w_accept && ((w_op == OP_LOAD_WEIGHT) || (w_op == OP_LOAD_INPUT));

   burst_addr_gen #(
      .ADDR_W (ADDR_W),
      .ROWS   (ROWS)
   ) u_burst (
      .clk    (clk),
      .reset  (reset),
      .start  (w_burst_start),
      .base   (r_base),
      .addr   (w_burst_addr),
      .active (w_burst_active),
      .last   (w_burst_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (w_op)
                  OP_LOAD_WEIGHT: w_state_next = S_BURST_W;
                  OP_LOAD_INPUT:  w_state_next = S_BURST_I;
                  OP_RUN:         w_state_next = S_KICK;
                  OP_HALT:        w_state_next = S_HALT;
                  default:        w_state_next = S_IDLE;
               endcase
            end
         end
         S_BURST_W, S_BURST_I: if (w_burst_last) w_state_next = S_IDLE;
         S_KICK:               w_state_next = S_WAIT;
         S_WAIT:               if (compute_done) w_state_next = S_IDLE;
         S_HALT:               w_state_next = S_HALT;
         default:              w_state_next = S_IDLE;
      endcase
   end

   // Base address latch and sticky illegal-opcode flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_base    <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         if (w_op == OP_LOAD_ADDR) r_base <= w_operand;
         if (is_illegal(w_op))     r_illegal <= 1'b1;
      end
   end

   assign instr_ready  = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted       = (r_state == S_HALT);
   assign start        = (r_state == S_KICK);
   assign load_weight  = (r_state == S_BURST_W) && w_burst_active;
   assign load_input   = (r_state == S_BURST_I) && w_burst_active;
   assign mem_addr     = (load_weight || load_input) ? w_burst_addr : '0;
   assign base_address = r_base;
   assign illegal      = r_illegal;

`ifdef INSTR_SEQUENCER_PERF_EN
   logic [31:0] r_busy_cycles;

   // Saturating count of busy cycles.
   always_ff @(posedge clk) begin
      if (reset)                              r_busy_cycles <= '0;
      else if (busy && (r_busy_cycles != '1)) r_busy_cycles <= r_busy_cycles + 32'd1;
   end

   assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a queue-based strobe scoreboard.
module tb_instr_sequencer;

   localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, LDW = 3'b010, LDI = 3'b011;
   localparam logic [2:0] RUN = 3'b100, BAD = 3'b101, HLT = 3'b111;
   localparam int K_W = 1, K_I = 2, K_S = 3;

   typedef struct {
      int          kind;
      logic [12:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        compute_done;
   logic [12:0] base_address;
   logic [12:0] mem_addr;
   logic        load_weight;
   logic        load_input;
   logic        start;
   logic        busy;
   logic        halted;
   logic        illegal;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   instr_sequencer #(.INSTR_W(16), .ADDR_W(13), .ROWS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .compute_done (compute_done),
      .base_address (base_address),
      .mem_addr     (mem_addr),
      .load_weight  (load_weight),
      .load_input   (load_input),
      .start        (start),
      .busy         (busy),
      .halted       (halted),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [12:0] addr);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [2:0] op, input logic [12:0] operand);
      int unsigned waited = 0;
      while (!instr_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("issue_ready", {31'd0, instr_ready}, 32'd1);
      instr       = {op, operand};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   // Monitor: every strobe cycle must match the next queued expectation.
   always @(negedge clk) begin
      check("strobe_excl", {31'd0, load_weight & load_input}, 32'd0);
      if (load_weight || load_input || start) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got lw=%0b li=%0b st=%0b addr=0x%0h expected none at %0t",
                     load_weight, load_input, start, mem_addr, $time);
         end else begin
            exp_t e;
            int   k;
            e = exp_q.pop_front();
            k = load_weight ? K_W : (load_input ? K_I : K_S);
            check("strobe_kind", k, e.kind);
            check("strobe_addr", {19'd0, mem_addr}, {19'd0, e.addr});
         end
      end else begin
         check("mem_addr_idle", {19'd0, mem_addr}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; instr = '0; instr_valid = 1'b0; compute_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_base", {19'd0, base_address}, 32'd0);

      // NOP and a stray compute_done in IDLE change nothing.
      @(posedge clk); #1;
      issue(NOP, 13'h0123);
      compute_done = 1'b1;
      @(negedge clk);
      check("nop_base", {19'd0, base_address}, 32'd0);
      check("nop_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 compute_done = 1'b0;
      @(negedge clk);
      check("done_idle_ready", {31'd0, instr_ready}, 32'd1);

      // Weight burst from 0x0010.
      @(posedge clk); #1;
      issue(LDA, 13'h0010);
      @(negedge clk);
      check("lda_base", {19'd0, base_address}, 32'h10);
      for (int i = 0; i < 4; i++) push(K_W, 13'(13'h0010 + i));
      @(posedge clk); #1;
      issue(LDW, 13'h0000);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("burst_w_ready", {31'd0, instr_ready}, 32'd0);
         check("burst_w_busy", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      check("after_w_ready", {31'd0, instr_ready}, 32'd1);
      check("after_w_q", exp_q.size(), 32'd0);

      // Input burst wrapping across the top of the address space.
      @(posedge clk); #1;
      issue(LDA, 13'h1FFE);
      push(K_I, 13'h1FFE); push(K_I, 13'h1FFF); push(K_I, 13'h0000); push(K_I, 13'h0001);
      issue(LDI, 13'h0000);
      repeat (5) @(negedge clk);
      check("after_i_ready", {31'd0, instr_ready}, 32'd1);
      check("after_i_q", exp_q.size(), 32'd0);
      check("after_i_base", {19'd0, base_address}, 32'h1FFE);

      // RUN: start one cycle, done sampled 5 cycles after start.
      @(posedge clk); #1;
      push(K_S, 13'h0000);
      issue(RUN, 13'h0000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("run_busy", {31'd0, busy}, 32'd1);
         check("run_ready", {31'd0, instr_ready}, 32'd0);
         @(posedge clk); #1;
      end
      compute_done = 1'b1;
      @(negedge clk);
      check("run_busy_done", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 compute_done = 1'b0;
      @(negedge clk);
      check("run_ready_after", {31'd0, instr_ready}, 32'd1);
      check("run_busy_after", {31'd0, busy}, 32'd0);
      check("run_q", exp_q.size(), 32'd0);

      // Reserved opcode sets sticky illegal and acts as NOP.
      @(posedge clk); #1;
      issue(BAD, 13'h0777);
      @(negedge clk);
      check("ill_flag", {31'd0, illegal}, 32'd1);
      check("ill_ready", {31'd0, instr_ready}, 32'd1);
      check("ill_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      issue(LDA, 13'h0003);
      @(negedge clk);
      check("ill_base", {19'd0, base_address}, 32'h3);
      check("ill_sticky", {31'd0, illegal}, 32'd1);

      // Reset on the third burst cycle.
      @(posedge clk); #1;
      issue(LDA, 13'h0020);
      push(K_W, 13'h0020); push(K_W, 13'h0021); push(K_W, 13'h0022);
      issue(LDW, 13'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rstb_lw", {31'd0, load_weight}, 32'd0);
      check("rstb_addr", {19'd0, mem_addr}, 32'd0);
      check("rstb_busy", {31'd0, busy}, 32'd0);
      check("rstb_ready", {31'd0, instr_ready}, 32'd1);
      check("rstb_illegal", {31'd0, illegal}, 32'd0);
      check("rstb_base", {19'd0, base_address}, 32'd0);
      check("rstb_q", exp_q.size(), 32'd0);

      // HALT locks out further instructions until reset.
      @(posedge clk); #1;
      issue(LDA, 13'h00AA);
      issue(HLT, 13'h0000);
      @(negedge clk);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_ready", {31'd0, instr_ready}, 32'd0);
      check("halt_busy", {31'd0, busy}, 32'd0);
      instr = {LDA, 13'h0155};
      instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("halt_hold", {31'd0, halted}, 32'd1);
         check("halt_base", {19'd0, base_address}, 32'hAA);
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("halt_cleared", {31'd0, halted}, 32'd1 - 32'd1);
      check("halt_rst_ready", {31'd0, instr_ready}, 32'd1);
      check("final_q", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
